pe_compute_unit: RTL and testbench

PE_COMPUTE_UNIT -- requirements
Module: pe_compute_unit

---
 rtl/pe_pkg.sv | 22 ++
 rtl/pe_compute_unit_if.sv | 34 +++
 rtl/pe_lane_alu.sv | 24 ++
 rtl/pe_compute_unit.sv | 121 ++++++++++++
 tb/tb_pe_compute_unit.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE datapath and the fetch unit that feeds it.
package pe_pkg;

  localparam int unsigned DATA_LEN    = 32;
  localparam int unsigned LANES       = 4;
  localparam int unsigned PE_OPCODE_W = 3;
  localparam int unsigned OP_COUNT_W  = 16;

  typedef enum logic [PE_OPCODE_W-1:0] {
    NOP  = 3'd0,
    ADD  = 3'd1,
    SUB  = 3'd2,
    MUL  = 3'd3,
    DOTP = 3'd4
  } pe_op_t;

  // Reserved encodings 5-7 behave like NOP and are never issued.
  function automatic logic op_is_issuable(input logic [PE_OPCODE_W-1:0] code);
    return (code >= PE_OPCODE_W'(ADD)) && (code <= PE_OPCODE_W'(DOTP));
  endfunction

endpackage

// File: rtl/pe_compute_unit_if.sv
// Issue and result bundle between the fetch side and the PE compute unit.
interface pe_compute_unit_if #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned LANES    = 4
);

  localparam int unsigned VEC_W = DATA_LEN * LANES;

  logic [pe_pkg::PE_OPCODE_W-1:0] pe_opcode;
  logic [VEC_W-1:0]               data_a;
  logic [VEC_W-1:0]               data_b;
  logic                           stop;
  logic [VEC_W-1:0]               pe_stage_1_output;
  logic                           pe_stage_1_valid;
  logic [DATA_LEN-1:0]            pe_stage_2_output;
  logic                           pe_stage_2_valid;
  logic                           busy;
  logic [pe_pkg::OP_COUNT_W-1:0]  op_count;

  modport master (
    output pe_opcode, data_a, data_b, stop,
    input  pe_stage_1_output, pe_stage_1_valid,
    input  pe_stage_2_output, pe_stage_2_valid,
    input  busy, op_count
  );

  modport slave (
    input  pe_opcode, data_a, data_b, stop,
    output pe_stage_1_output, pe_stage_1_valid,
    output pe_stage_2_output, pe_stage_2_valid,
    output busy, op_count
  );

endinterface

// File: rtl/pe_lane_alu.sv
// Single-lane combinational arithmetic; DOTP produces the lane product.
module pe_lane_alu
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  pe_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_c
);

  // Modulo-2^WIDTH result; the product keeps only its low WIDTH bits.
  always_comb begin
    y_c = '0;
    case (op)
      ADD:       y_c = a + b;
      SUB:       y_c = a - b;
      MUL, DOTP: y_c = a * b;
      default:   y_c = '0;
    endcase
  end

endmodule

// File: rtl/pe_compute_unit.sv
// Two-stage SIMD PE: lane-wise ALU result at +1 cycle, dot-product sum at +2.
module pe_compute_unit #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned LANES    = 4
) (
  input logic              clk,
  input logic              rst,
  pe_compute_unit_if.slave bus
);

  import pe_pkg::pe_op_t;
  import pe_pkg::NOP;
  import pe_pkg::DOTP;
  import pe_pkg::OP_COUNT_W;
  import pe_pkg::op_is_issuable;

  localparam int unsigned VEC_W = DATA_LEN * LANES;

  logic                  accept_c;
  pe_op_t                op_q;
  logic [VEC_W-1:0]      a_q;
  logic [VEC_W-1:0]      b_q;
  logic                  issue_q;
  logic [VEC_W-1:0]      lane_res_c;
  logic [VEC_W-1:0]      stage1_q;
  logic                  stage1_valid_q;
  logic                  reduce_q;
  logic [DATA_LEN-1:0]   dot_sum_c;
  logic [DATA_LEN-1:0]   stage2_q;
  logic                  stage2_valid_q;
  logic                  busy_q;
  logic [OP_COUNT_W-1:0] count_q;

  assign accept_c = op_is_issuable(bus.pe_opcode) && !bus.stop;

  // Issue register: capture opcode and operands of every accepted op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= NOP;
      a_q     <= '0;
      b_q     <= '0;
      issue_q <= 1'b0;
    end else begin
      issue_q <= accept_c;
      if (accept_c) begin
        op_q <= pe_op_t'(bus.pe_opcode);
        a_q  <= bus.data_a;
        b_q  <= bus.data_b;
      end
    end
  end

  // One ALU per lane operating on the registered operands.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_lane_alu #(
      .WIDTH(DATA_LEN)
    ) u_alu (
      .op  (op_q),
      .a   (a_q[i*DATA_LEN +: DATA_LEN]),
      .b   (b_q[i*DATA_LEN +: DATA_LEN]),
      .y_c (lane_res_c[i*DATA_LEN +: DATA_LEN])
    );
  end

  // Stage 1: publish lane results and mark DOTPs for reduction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1_q       <= '0;
      stage1_valid_q <= 1'b0;
      reduce_q       <= 1'b0;
    end else begin
      stage1_valid_q <= issue_q;
      reduce_q       <= issue_q && (op_q == DOTP);
      if (issue_q) begin
        stage1_q <= lane_res_c;
      end
    end
  end

  // Modulo-2^DATA_LEN sum of the published lane products.
  always_comb begin
    dot_sum_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      dot_sum_c = dot_sum_c + stage1_q[i*DATA_LEN +: DATA_LEN];
    end
  end

  // Stage 2: reduction result, only ever written by a DOTP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage2_q       <= '0;
      stage2_valid_q <= 1'b0;
    end else begin
      stage2_valid_q <= reduce_q;
      if (reduce_q) begin
        stage2_q <= dot_sum_c;
      end
    end
  end

  // Busy mirrors the next values of both occupancy bits; counter tracks accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      busy_q <= accept_c || (issue_q && (op_q == DOTP));
      if (accept_c) begin
        count_q <= count_q + OP_COUNT_W'(1);
      end
    end
  end

  assign bus.pe_stage_1_output = stage1_q;
  assign bus.pe_stage_1_valid  = stage1_valid_q;
  assign bus.pe_stage_2_output = stage2_q;
  assign bus.pe_stage_2_valid  = stage2_valid_q;
  assign bus.busy              = busy_q;
  assign bus.op_count          = count_q;

endmodule

// File: tb/tb_pe_compute_unit.sv
// Self-checking bench for pe_compute_unit: directed table, corner sequences, random traffic.
module tb_pe_compute_unit;

  localparam int unsigned DL = 32;
  localparam int unsigned NL = 4;

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] e1;
    logic [31:0]  e2;
  } vec_t;

  typedef struct {
    bit           acc;
    logic [2:0]   op;
    logic [127:0] r1;
    logic [31:0]  r2;
  } slot_t;

  logic clk;
  logic rst;

  pe_compute_unit_if #(.DATA_LEN(DL), .LANES(NL)) bus ();

  pe_compute_unit #(.DATA_LEN(DL), .LANES(NL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference state: ops accepted one and two edges ago, held outputs, op count.
  slot_t        m1;
  slot_t        m2;
  logic [127:0] h1;
  logic [31:0]  h2;
  logic [15:0]  cnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Lane-wise reference using 64-bit arithmetic truncated to the lane width.
  function automatic logic [127:0] model_lanes(input logic [2:0] op, input logic [127:0] a,
                                               input logic [127:0] b);
    logic [127:0] r;
    logic [63:0]  x;
    logic [63:0]  y;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      x = 64'(a[i*32 +: 32]);
      y = 64'(b[i*32 +: 32]);
      case (op)
        3'd1:       r[i*32 +: 32] = 32'(x + y);
        3'd2:       r[i*32 +: 32] = 32'(x - y);
        3'd3, 3'd4: r[i*32 +: 32] = 32'(x * y);
        default:    r[i*32 +: 32] = 32'd0;
      endcase
    end
    return r;
  endfunction

  // Dot product: sum of full 64-bit products, keep low 32 bits.
  function automatic logic [31:0] model_dot(input logic [127:0] a, input logic [127:0] b);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s = s + 64'(a[i*32 +: 32]) * 64'(b[i*32 +: 32]);
    end
    return s[31:0];
  endfunction

  // Drive one cycle of inputs, clock it, and check every output against the model.
  task automatic run_cycle(input logic [2:0] op, input logic [127:0] a, input logic [127:0] b,
                           input logic stp);
    slot_t cur;
    logic  ev1;
    logic  ev2;
    logic  ebusy;
    bus.pe_opcode = op;
    bus.data_a    = a;
    bus.data_b    = b;
    bus.stop      = stp;
    cur.acc = (op >= 3'd1) && (op <= 3'd4) && !stp;
    cur.op  = op;
    cur.r1  = model_lanes(op, a, b);
    cur.r2  = model_dot(a, b);
    @(posedge clk);
    #1;
    ev1   = m1.acc;
    ev2   = m2.acc && (m2.op == 3'd4);
    ebusy = cur.acc || (m1.acc && (m1.op == 3'd4));
    if (ev1) h1 = m1.r1;
    if (ev2) h2 = m2.r2;
    if (cur.acc) cnt = cnt + 16'd1;
    check("stage1_valid", 128'(bus.pe_stage_1_valid), 128'(ev1));
    check("stage1_output", bus.pe_stage_1_output, h1);
    check("stage2_valid", 128'(bus.pe_stage_2_valid), 128'(ev2));
    check("stage2_output", 128'(bus.pe_stage_2_output), 128'(h2));
    check("busy", 128'(bus.busy), 128'(ebusy));
    check("op_count", 128'(bus.op_count), 128'(cnt));
    m2 = m1;
    m1 = cur;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(3'd0, '0, '0, 1'b0);
  endtask

  // Assert reset mid-cycle, check outputs clear at once, then release.
  task automatic apply_reset();
    bus.pe_opcode = 3'd0;
    bus.data_a    = '0;
    bus.data_b    = '0;
    bus.stop      = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_stage1_output", bus.pe_stage_1_output, '0);
    check("rst_stage1_valid", 128'(bus.pe_stage_1_valid), '0);
    check("rst_stage2_output", 128'(bus.pe_stage_2_output), '0);
    check("rst_stage2_valid", 128'(bus.pe_stage_2_valid), '0);
    check("rst_busy", 128'(bus.busy), '0);
    check("rst_op_count", 128'(bus.op_count), '0);
    m1  = '{acc: 1'b0, op: 3'd0, r1: '0, r2: '0};
    m2  = m1;
    h1  = '0;
    h2  = '0;
    cnt = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    logic [127:0] a1234;
    logic [127:0] b5678;
    logic [127:0] ra;
    logic [127:0] rb;

    a1234 = {32'd4, 32'd3, 32'd2, 32'd1};
    b5678 = {32'd8, 32'd7, 32'd6, 32'd5};
    tbl[0] = '{"add_5_6",  3'd1, {4{32'd5}}, {4{32'd6}}, {4{32'd11}}, 32'd0};
    tbl[1] = '{"sub_5_6",  3'd2, {4{32'd5}}, {4{32'd6}}, {4{32'hFFFF_FFFF}}, 32'd0};
    tbl[2] = '{"mul_5_6",  3'd3, {4{32'd5}}, {4{32'd6}}, {4{32'd30}}, 32'd0};
    tbl[3] = '{"dotp_1234_5678", 3'd4, a1234, b5678, {32'd32, 32'd21, 32'd12, 32'd5}, 32'd70};
    tbl[4] = '{"add_wrap", 3'd1, {4{32'hFFFF_FFFF}}, {4{32'd1}}, '0, 32'd0};
    tbl[5] = '{"mul_wrap", 3'd3, {4{32'h0001_0000}}, {4{32'h0001_0000}}, '0, 32'd0};

    rst = 1'b1;
    apply_reset();

    // Directed table: result one cycle after issue, sum two cycles after a DOTP.
    for (int i = 0; i < 6; i++) begin
      run_cycle(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0);
      run_cycle(3'd0, '0, '0, 1'b0);
      check({tbl[i].name, "_s1"}, bus.pe_stage_1_output, tbl[i].e1);
      check({tbl[i].name, "_v1"}, 128'(bus.pe_stage_1_valid), 128'(1'b1));
      run_cycle(3'd0, '0, '0, 1'b0);
      if (tbl[i].op == 3'd4) begin
        check({tbl[i].name, "_s2"}, 128'(bus.pe_stage_2_output), 128'(tbl[i].e2));
        check({tbl[i].name, "_v2"}, 128'(bus.pe_stage_2_valid), 128'(1'b1));
      end
    end

    // Back-to-back ADD, DOTP, MUL, DOTP from a fresh count.
    apply_reset();
    run_cycle(3'd1, {4{32'd5}}, {4{32'd6}}, 1'b0);
    run_cycle(3'd4, a1234, b5678, 1'b0);
    run_cycle(3'd3, {4{32'd5}}, {4{32'd6}}, 1'b0);
    run_cycle(3'd4, {4{32'd2}}, {4{32'd3}}, 1'b0);
    run_cycle(3'd0, '0, '0, 1'b0);
    check("b2b_second_sum", 128'(bus.pe_stage_2_output), 128'(32'd70));
    run_cycle(3'd0, '0, '0, 1'b0);
    check("b2b_fourth_sum", 128'(bus.pe_stage_2_output), 128'(32'd24));
    check("b2b_op_count", 128'(bus.op_count), 128'(16'd4));
    idle(2);

    // DOTP issued just before stop rises still completes; stalled DOTPs do not.
    apply_reset();
    run_cycle(3'd4, a1234, b5678, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(3'd4, {4{32'd9}}, {4{32'd9}}, 1'b1);
    idle(2);
    check("stop_op_count", 128'(bus.op_count), 128'(16'd1));
    check("stop_sum_kept", 128'(bus.pe_stage_2_output), 128'(32'd70));

    // Reset one cycle after a DOTP issue discards it.
    run_cycle(3'd4, {4{32'd3}}, {4{32'd4}}, 1'b0);
    run_cycle(3'd0, '0, '0, 1'b0);
    apply_reset();
    idle(3);

    // First op is accepted on the first edge after release.
    apply_reset();
    run_cycle(3'd2, {4{32'd10}}, {4{32'd3}}, 1'b0);
    idle(2);

    // Random traffic including reserved opcodes and stop.
    for (int k = 0; k < 400; k++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      run_cycle(3'($urandom_range(0, 7)), ra, rb, ($urandom_range(0, 3) == 0));
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
